// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write FIFO; queued bytes are sent
// back-to-back with no idle gap, LSB first, CLKS_PER_BIT clocks per bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          ser_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg, level_reg;
  logic [AW:0] wr_ptr_next, rd_ptr_next, level_next;
  logic        full, empty, push, pop;
  logic [7:0]  rd_data;

  state_t      state_reg, state_next;
  logic [15:0] baud_reg, baud_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        ser_tx_reg, ser_tx_next;
  logic        busy_reg, busy_next;
  logic        baud_last;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign wr_ready = !full && !rst;
  assign push     = wr_valid && wr_ready;
  assign rd_data  = mem[rd_ptr_reg[AW-1:0]];

  assign baud_last = (baud_reg == BAUD_LAST);

  assign ser_tx  = ser_tx_reg;
  assign tx_busy = busy_reg;
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg + (push ? 1'b1 : 1'b0);
    rd_ptr_next = rd_ptr_reg + (pop ? 1'b1 : 1'b0);
    level_next  = level_reg;
    if (push && !pop) begin
      level_next = level_reg + 1'b1;
    end else if (pop && !push) begin
      level_next = level_reg - 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (!empty) state_next = START;
      START: if (baud_last) state_next = DATA;
      DATA:  if (baud_last && bit_reg == 3'd7) state_next = STOP;
      STOP:  if (baud_last) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath logic; ser_tx/tx_busy are computed one cycle ahead
  // so that the registered line changes together with the state.
  always_comb begin
    pop         = 1'b0;
    ser_tx_next = ser_tx_reg;
    busy_next   = busy_reg;
    baud_next   = baud_last ? 16'd0 : baud_reg + 16'd1;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    case (state_reg)
      IDLE: begin
        baud_next   = 16'd0;
        ser_tx_next = 1'b1;
        busy_next   = 1'b0;
        if (!empty) begin
          pop         = 1'b1;
          shift_next  = rd_data;
          bit_next    = 3'd0;
          ser_tx_next = 1'b0;
          busy_next   = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          ser_tx_next = shift_reg[0];
          bit_next    = 3'd0;
        end
      end
      DATA: begin
        if (baud_last) begin
          bit_next = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            ser_tx_next = 1'b1;
          end else begin
            ser_tx_next = shift_reg[1];
            shift_next  = {1'b0, shift_reg[7:1]};
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          if (!empty) begin
            pop         = 1'b1;
            shift_next  = rd_data;
            bit_next    = 3'd0;
            ser_tx_next = 1'b0;
          end else begin
            ser_tx_next = 1'b1;
            busy_next   = 1'b0;
          end
        end
      end
      default: begin
        ser_tx_next = 1'b1;
        busy_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      baud_reg   <= 16'd0;
      bit_reg    <= 3'd0;
      shift_reg  <= 8'd0;
      ser_tx_reg <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      ser_tx_reg <= ser_tx_next;
      busy_reg   <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: exact line timing plus an 8N1 receiver
// model that decodes everything the transmitter puts on ser_tx.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       ser_tx;
  logic       tx_busy;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(10), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .ser_tx(ser_tx), .tx_busy(tx_busy), .level(level)
  );

  always #5 clk = ~clk;

  // Receiver model, sampling mid-bit at 10 clocks per bit
  int         rst_edges = 0;
  int         rst_edges_seen = 0;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'd0;
  int         rx_ferr = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (rst) rst_edges <= rst_edges + 1;
  end

  always @(negedge clk) begin
    if (rst_edges != rst_edges_seen) begin
      rst_edges_seen <= rst_edges;
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (ser_tx == 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt + 1 >= 15 && rx_cnt + 1 < 95 && (rx_cnt + 1) % 10 == 5)
        rx_sh <= {ser_tx, rx_sh[7:1]};
      if (rx_cnt + 1 == 95) begin
        if (ser_tx != 1'b1) rx_ferr <= rx_ferr + 1;
        rx_q.push_back(rx_sh);
        rx_act <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at the sample after the start-bit edge; ends one sample past the frame.
  task automatic expect_frame(input logic [7:0] b);
    logic [7:0] sh;
    logic       e;
    for (int i = 0; i < 100; i++) begin
      if (i < 10) e = 1'b0;
      else if (i < 90) begin
        sh = b >> ((i - 10) / 10);
        e  = sh[0];
      end else e = 1'b1;
      chk("frame", {30'd0, tx_busy, ser_tx}, {30'd0, 1'b1, e});
      tick();
    end
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while ((tx_busy || level != 5'd0) && n < max) begin
      tick();
      n++;
    end
    chk(tag, (n < max) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int q0;
  int lows;
  logic [7:0] hello [6];

  initial begin
    hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C;
    hello[3] = 8'h6C; hello[4] = 8'h6F; hello[5] = 8'h0A;
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    tick(); tick();
    chk("rst_ser_tx", ser_tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 0);
    rst = 1'b0;
    #1 chk("wr_ready_after_rst", wr_ready, 1);
    tick(); tick();

    // Single byte 0x55 with exact latency
    wr_data = 8'h55; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("lat_level1", level, 1);
    chk("lat_ser_idle", ser_tx, 1);
    chk("lat_busy0", tx_busy, 0);
    tick();
    chk("lat_level0", level, 0);
    expect_frame(8'h55);
    chk("single_busy_fall", tx_busy, 0);
    chk("single_ser_idle", ser_tx, 1);
    tick(); tick();

    // Back-to-back 0x00, 0xFF
    wr_data = 8'h00; wr_valid = 1'b1;
    tick();
    wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    expect_frame(8'h00);
    expect_frame(8'hFF);
    chk("b2b_busy_fall", tx_busy, 0);
    tick(); tick();

    // Fill the FIFO; the 18th byte must be refused
    q0 = rx_q.size();
    for (int k = 0; k < 17; k++) begin
      wr_data = 8'h10 + 8'(k); wr_valid = 1'b1;
      tick();
    end
    chk("full_level16", level, 16);
    chk("full_wr_ready", wr_ready, 0);
    wr_data = 8'h21;
    tick();
    wr_valid = 1'b0;
    chk("full_level_hold", level, 16);
    wait_idle(2500, "full_drain_timeout");
    chk("full_rx_count", rx_q.size() - q0, 17);
    for (int i = 0; i < 17; i++)
      chk("full_rx_byte", rx_q[q0 + i], 8'h10 + 8'(i));
    tick(); tick();

    // Push on the final stop cycle at level 3
    q0 = rx_q.size();
    for (int k = 0; k < 4; k++) begin
      wr_data = 8'hA0 + 8'(k); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    repeat (97) tick();
    chk("pp_level_before", level, 3);
    chk("pp_stop_bit", ser_tx, 1);
    wr_data = 8'hA4; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("pp_level_same", level, 3);
    chk("pp_start_nogap", ser_tx, 0);
    chk("pp_busy", tx_busy, 1);
    wait_idle(700, "pp_drain_timeout");
    chk("pp_rx_count", rx_q.size() - q0, 5);
    for (int i = 0; i < 5; i++)
      chk("pp_rx_byte", rx_q[q0 + i], 8'hA0 + 8'(i));
    tick(); tick();

    // Reset during bit 4 of 0xA5 with two bytes queued
    q0 = rx_q.size();
    wr_data = 8'hA5; wr_valid = 1'b1; tick();
    wr_data = 8'hB1; tick();
    wr_data = 8'hB2; tick();
    wr_valid = 1'b0;
    repeat (53) tick();
    chk("rst_mid_bit4", ser_tx, 0);
    chk("rst_mid_level2", level, 2);
    rst = 1'b1;
    tick();
    chk("rst_mid_ser", ser_tx, 1);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_busy", tx_busy, 0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ser_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    chk("rst_mid_quiet", lows, 0);
    chk("rst_mid_no_rx", rx_q.size() - q0, 0);

    // Loopback "Hello\n"
    q0 = rx_q.size();
    for (int k = 0; k < 6; k++) begin
      wr_data = hello[k]; wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    wait_idle(1000, "hello_drain_timeout");
    chk("hello_rx_count", rx_q.size() - q0, 6);
    for (int i = 0; i < 6; i++)
      chk("hello_rx_byte", rx_q[q0 + i], hello[i]);
    chk("rx_framing_errors", rx_ferr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
